instr_encoder_loader: RTL

- Reverse of the core's field decoder. Accepts decoded RV32I instruction fields over a valid/ready stream and packs them into 32-bit instruction words.
- Writes the words sequentially into instruction memory through a granted write port.
- Used by the test harness and the boot path to load programs without a pre-assembled hex image.
- One load job has a programmable base address and instruction count.

---
 rtl/types_pkg.sv | 43 ++++
 rtl/instr_packer.sv | 70 +++++++
 rtl/instr_encoder_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared RV32I field types and bit positions, used by both the decoder and the encoder/loader.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package types_pkg;

    // Instruction formats. Encodings 6 and 7 are undefined and pack as a NOP.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef logic [4:0] reg_addr_t;

    // LSB positions of the fixed-location fields in a 32-bit instruction word.
    localparam int OP_LSB     = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0, x0, 0

    // True when the immediate fits the encoding of the given format without loss.
    function automatic logic imm_in_range(logic [2:0] fmt, logic [31:0] imm);
        logic signed [31:0] s;
        logic               ok;
        s = signed'(imm);
        case (fmt)
            FMT_I, FMT_S: ok = (s >= -32'sd2048) && (s <= 32'sd2047);
            FMT_B:        ok = (s >= -32'sd4096) && (s <= 32'sd4094) && !imm[0];
            FMT_J:        ok = (s >= -32'sd1048576) && (s <= 32'sd1048574) && !imm[0];
            FMT_U:        ok = (imm[11:0] == 12'h000);
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_packer.sv
// Packs decoded RV32I fields into a 32-bit instruction word.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
//
// Ports: fmt/op/rd/rs1/rs2/funct3/funct7/imm in, word out.
// Fields unused by a format are ignored; an undefined fmt yields a NOP.
module instr_packer
    import types_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        word[OP_LSB +: 7] = op;
        case (fmt)
            FMT_R: begin
                word[FUNCT7_LSB +: 7] = funct7;
                word[RS2_LSB +: 5]    = rs2;
                word[RS1_LSB +: 5]    = rs1;
                word[FUNCT3_LSB +: 3] = funct3;
                word[RD_LSB +: 5]     = rd;
            end
            FMT_I: begin
                word[31:20]           = imm[11:0];
                word[RS1_LSB +: 5]    = rs1;
                word[FUNCT3_LSB +: 3] = funct3;
                word[RD_LSB +: 5]     = rd;
            end
            FMT_S: begin
                word[31:25]           = imm[11:5];
                word[11:7]            = imm[4:0];
                word[RS2_LSB +: 5]    = rs2;
                word[RS1_LSB +: 5]    = rs1;
                word[FUNCT3_LSB +: 3] = funct3;
            end
            FMT_B: begin
                // imm[0] is implicitly zero in branch offsets and is not stored.
                word[31]              = imm[12];
                word[30:25]           = imm[10:5];
                word[11:8]            = imm[4:1];
                word[7]               = imm[11];
                word[RS2_LSB +: 5]    = rs2;
                word[RS1_LSB +: 5]    = rs1;
                word[FUNCT3_LSB +: 3] = funct3;
            end
            FMT_U: begin
                word[31:12]           = imm[31:12];
                word[RD_LSB +: 5]     = rd;
            end
            FMT_J: begin
                word[31]              = imm[20];
                word[30:21]           = imm[10:1];
                word[20]              = imm[11];
                word[19:12]           = imm[19:12];
                word[RD_LSB +: 5]     = rd;
            end
            default: word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes a stream of decoded RV32I field bundles and writes them sequentially into instruction memory.
// Latency: 1 cycle from bundle accept to mem_we.
// Backpressure: in_ready drops while a registered word waits for mem_gnt; full rate when gnt stays high.
//
// Ports: clk, rst (async, active high); start/base_addr/count job control; in_* field stream
// (valid/ready); mem_we/mem_gnt/mem_addr/mem_wdata write port; busy, done (1-cycle pulse), err (sticky).
// Optional build macro IMM_RANGE_CHECK_EN: out-of-range immediates set err and leave an address hole
// instead of being written; without it immediates are truncated and err is tied low.
module instr_encoder_loader
    import types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remain_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [31:0]       packed_word;
    logic              accept;
    logic              imm_bad;
    logic              job_start;

    instr_packer u_packer (
        .fmt    (in_fmt),
        .op     (in_op),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (packed_word)
    );

    // A new bundle may enter whenever the output register is empty or is being drained this cycle.
    assign in_ready  = (state_q == ST_LOAD) && (!we_q || mem_gnt);
    assign accept    = in_valid && in_ready;
    assign job_start = (state_q == ST_IDLE) && start;

`ifdef IMM_RANGE_CHECK_EN
    assign imm_bad = !imm_in_range(in_fmt, in_imm);
`else
    assign imm_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (count != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (accept && (remain_q == CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Register may already be empty if the last bundle was rejected for its immediate.
                if (!we_q || mem_gnt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            remain_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            if (job_start) begin
                ptr_q    <= base_addr & ~ADDR_W'(3);
                remain_q <= count;
            end else if (accept) begin
                ptr_q <= ptr_q + ADDR_W'(4);
                if (remain_q != '0) begin
                    remain_q <= remain_q - CNT_W'(1);
                end
            end

            // A same-cycle accept overwrites the word being granted, so there is no bubble.
            if (accept && !imm_bad) begin
                we_q    <= 1'b1;
                addr_q  <= ptr_q;
                wdata_q <= packed_word;
            end else if (accept || mem_gnt) begin
                we_q <= 1'b0;
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (job_start) begin
            err_q <= 1'b0;
        end else if (accept && imm_bad) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
